// File: rtl/dout_bus_arbiter.sv
// Round-robin owner of the shared 4-bit output bus: each grant is a LEAD / XFER / GAP frame.
// Req at edge n gives Gnt and ExtClk_En from cycle n+1; the granted producer sees Ready only in XFER.
module dout_bus_arbiter #(
  parameter int LEAD_CYCLES = 2,
  parameter int GAP_CYCLES  = 2,
  parameter int STALL_MAX   = 8
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       Req0,
  input  logic [3:0] Len0,
  input  logic [3:0] Din0,
  input  logic       Din0_Valid,
  output logic       Din0_Ready,
  input  logic       Req1,
  input  logic [3:0] Len1,
  input  logic [3:0] Din1,
  input  logic       Din1_Valid,
  output logic       Din1_Ready,
  output logic [1:0] Gnt,
  output logic [3:0] Dout,
  output logic       Dout_Valid,
  output logic       ExtClk_En,
  output logic       Abort,
  output logic       Busy
);

  localparam int PMAX = (LEAD_CYCLES > GAP_CYCLES) ? LEAD_CYCLES : GAP_CYCLES;
  localparam int PW   = (PMAX > 1) ? $clog2(PMAX) : 1;
  localparam int SW   = $clog2(STALL_MAX + 1);
  localparam logic [PW-1:0] LEAD_LAST  = PW'(LEAD_CYCLES - 1);
  localparam logic [PW-1:0] GAP_LAST   = PW'(GAP_CYCLES - 1);
  localparam logic [SW-1:0] STALL_LAST = SW'(STALL_MAX);

  typedef enum logic [1:0] {IDLE, LEAD, XFER, GAP} state_t;

  state_t        state_q;
  logic [1:0]    gnt_q;
  logic [3:0]    dout_q;
  logic          dout_vld_q;
  logic          extclk_q;
  logic          abort_q;
  logic          ptr_q;       // 1 = channel 1 preferred on a tie
  logic [3:0]    wcnt_q;
  logic [SW-1:0] stall_q;
  logic [PW-1:0] pcnt_q;      // shared by LEAD and GAP, never both active

  logic          win1;
  logic [3:0]    len_sel;
  logic [3:0]    len_eff;
  logic          hs;
  logic [3:0]    din_sel;
  logic [SW-1:0] stall_d;

  assign Din0_Ready = (state_q == XFER) & gnt_q[0];
  assign Din1_Ready = (state_q == XFER) & gnt_q[1];
  assign hs         = (Din0_Valid & Din0_Ready) | (Din1_Valid & Din1_Ready);
  assign din_sel    = gnt_q[1] ? Din1 : Din0;
  assign stall_d    = stall_q + 1'b1;

  assign win1    = Req1 & (~Req0 | ptr_q);
  assign len_sel = win1 ? Len1 : Len0;
  assign len_eff = (len_sel == 4'd0) ? 4'd1 : len_sel;

  assign Gnt        = gnt_q;
  assign Dout       = dout_q;
  assign Dout_Valid = dout_vld_q;
  assign ExtClk_En  = extclk_q;
  assign Abort      = abort_q;
  assign Busy       = (state_q != IDLE);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q    <= IDLE;
      gnt_q      <= 2'b00;
      dout_q     <= 4'd0;
      dout_vld_q <= 1'b0;
      extclk_q   <= 1'b0;
      abort_q    <= 1'b0;
      ptr_q      <= 1'b0;
      wcnt_q     <= 4'd0;
      stall_q    <= '0;
      pcnt_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          dout_vld_q <= 1'b0;
          abort_q    <= 1'b0;
          if (Req0 | Req1) begin
            state_q  <= LEAD;
            gnt_q    <= win1 ? 2'b10 : 2'b01;
            wcnt_q   <= len_eff;
            stall_q  <= '0;
            pcnt_q   <= '0;
            extclk_q <= 1'b1;
          end
        end
        LEAD: begin
          if (pcnt_q == LEAD_LAST) begin
            state_q <= XFER;
            pcnt_q  <= '0;
          end else begin
            pcnt_q <= pcnt_q + 1'b1;
          end
        end
        XFER: begin
          if (hs) begin
            dout_q     <= din_sel;
            dout_vld_q <= 1'b1;
            wcnt_q     <= wcnt_q - 4'd1;
            stall_q    <= '0;
            if (wcnt_q == 4'd1) begin
              state_q <= GAP;
              gnt_q   <= 2'b00;
              ptr_q   <= gnt_q[0];
            end
          end else begin
            dout_vld_q <= 1'b0;
            stall_q    <= stall_d;
            // Producer went quiet too long: give the bus up and flag it.
            if (stall_d == STALL_LAST) begin
              state_q <= GAP;
              gnt_q   <= 2'b00;
              ptr_q   <= gnt_q[0];
              abort_q <= 1'b1;
            end
          end
        end
        GAP: begin
          dout_vld_q <= 1'b0;
          abort_q    <= 1'b0;
          if (pcnt_q == GAP_LAST) begin
            state_q  <= IDLE;
            extclk_q <= 1'b0;
            pcnt_q   <= '0;
          end else begin
            pcnt_q <= pcnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dout_bus_arbiter.sv
// Directed bench for dout_bus_arbiter with LEAD=2, GAP=2, STALL_MAX=8.
module tb_dout_bus_arbiter;

  logic       CLK = 1'b0;
  logic       RSTn = 1'b0;
  logic       Req0 = 1'b0, Req1 = 1'b0;
  logic [3:0] Len0 = 4'd0, Len1 = 4'd0;
  logic [3:0] Din0 = 4'd0, Din1 = 4'd0;
  logic       Din0_Valid = 1'b0, Din1_Valid = 1'b0;
  logic       Din0_Ready, Din1_Ready;
  logic [1:0] Gnt;
  logic [3:0] Dout;
  logic       Dout_Valid, ExtClk_En, Abort, Busy;

  int n_checks = 0;
  int n_fails  = 0;

  dout_bus_arbiter #(.LEAD_CYCLES(2), .GAP_CYCLES(2), .STALL_MAX(8)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .Req0(Req0), .Len0(Len0), .Din0(Din0), .Din0_Valid(Din0_Valid), .Din0_Ready(Din0_Ready),
    .Req1(Req1), .Len1(Len1), .Din1(Din1), .Din1_Valid(Din1_Valid), .Din1_Ready(Din1_Ready),
    .Gnt(Gnt), .Dout(Dout), .Dout_Valid(Dout_Valid), .ExtClk_En(ExtClk_En),
    .Abort(Abort), .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (Busy && n < 50) begin tick(); n++; end
    n_checks++;
    if (Busy !== 1'b0) begin
      n_fails++;
      $display("FAIL %s_idle_timeout: Busy=%b required 0", name, Busy);
    end
  endtask

  task automatic wait_ready(input int ch, input string name);
    int n = 0;
    while (((ch == 0) ? Din0_Ready : Din1_Ready) !== 1'b1 && n < 20) begin tick(); n++; end
    n_checks++;
    if (((ch == 0) ? Din0_Ready : Din1_Ready) !== 1'b1) begin
      n_fails++;
      $display("FAIL %s_ready_timeout: Ready never rose on channel %0d", name, ch);
    end
  endtask

  task automatic test_reset;
    logic [11:0] obs;
    RSTn = 1'b0;
    tick(); tick();
    obs = {Gnt, Dout, Dout_Valid, ExtClk_En, Abort, Busy, Din0_Ready, Din1_Ready};
    n_checks++;
    if (obs !== 12'h000) begin
      n_fails++;
      $display("FAIL reset_values: outputs=%h required 000", obs);
    end
    RSTn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      obs = {Gnt, Dout, Dout_Valid, ExtClk_En, Abort, Busy, Din0_Ready, Din1_Ready};
      n_checks++;
      if (obs !== 12'h000) begin
        n_fails++;
        $display("FAIL idle_cycle%0d: outputs=%h required 000", i, obs);
      end
    end
  endtask

  task automatic test_single_burst;
    logic [1:0] eg   [9] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
    logic       ext  [9] = '{1, 1, 1, 1, 1, 1, 1, 0, 0};
    logic       dv   [9] = '{0, 0, 0, 1, 1, 1, 0, 0, 0};
    logic [3:0] dout [9] = '{4'h0, 4'h0, 4'h0, 4'hA, 4'hB, 4'hC, 4'hC, 4'hC, 4'hC};
    logic       rdy  [9] = '{0, 0, 1, 1, 1, 0, 0, 0, 0};
    logic [3:0] dat  [4] = '{4'hA, 4'hB, 4'hC, 4'h0};
    logic [7:0] obs, expv;
    logic       hs;
    int         idx = 0;
    Req0 = 1'b1; Len0 = 4'd3; Din0 = dat[0]; Din0_Valid = 1'b1;
    tick();
    Req0 = 1'b0;
    for (int k = 0; k < 9; k++) begin
      obs  = {Gnt, ExtClk_En, Dout_Valid, Dout, Din0_Ready};
      expv = {eg[k], ext[k], dv[k], dout[k], rdy[k]};
      n_checks++;
      if (obs !== expv) begin
        n_fails++;
        $display("FAIL burst_cycle_n+%0d: {Gnt,Ext,DV,Dout,Rdy}=%b required %b", k + 1, obs, expv);
      end
      hs = Din0_Ready & Din0_Valid;
      tick();
      if (hs && idx < 3) begin idx++; Din0 = dat[idx]; end
    end
    Din0_Valid = 1'b0;
    wait_idle("single");
  endtask

  task automatic test_contention;
    logic [1:0] expg [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [1:0] prev = 2'b00;
    logic       idle_seen = 1'b1;
    int         cnt = 0;
    RSTn = 1'b0; tick(); RSTn = 1'b1;
    Req0 = 1'b1; Req1 = 1'b1; Len0 = 4'd2; Len1 = 4'd2;
    Din0 = 4'h1; Din1 = 4'h2; Din0_Valid = 1'b1; Din1_Valid = 1'b1;
    for (int c = 0; c < 100 && cnt < 4; c++) begin
      tick();
      if (!Busy && !ExtClk_En) idle_seen = 1'b1;
      if (Gnt != 2'b00 && prev == 2'b00) begin
        n_checks++;
        if (Gnt !== expg[cnt]) begin
          n_fails++;
          $display("FAIL contention_grant%0d: Gnt=%b required %b", cnt, Gnt, expg[cnt]);
        end
        n_checks++;
        if (idle_seen !== 1'b1) begin
          n_fails++;
          $display("FAIL contention_idle_gap%0d: idle seen=%b required 1", cnt, idle_seen);
        end
        idle_seen = 1'b0;
        cnt++;
      end
      prev = Gnt;
    end
    n_checks++;
    if (cnt !== 4) begin
      n_fails++;
      $display("FAIL contention_grant_count: got %0d required 4", cnt);
    end
    Req0 = 1'b0; Req1 = 1'b0;
    wait_idle("contention");
    Din0_Valid = 1'b0; Din1_Valid = 1'b0;
  endtask

  task automatic test_backpressure;
    logic       vv   [4] = '{1, 0, 0, 1};
    logic [3:0] dd   [4] = '{4'h5, 4'hF, 4'hF, 4'h6};
    logic       edv  [4] = '{1, 0, 0, 1};
    logic [3:0] edo  [4] = '{4'h5, 4'h5, 4'h5, 4'h6};
    int         words = 0, aborts = 0;
    Req1 = 1'b1; Len1 = 4'd2;
    tick();
    Req1 = 1'b0;
    wait_ready(1, "backpressure");
    for (int i = 0; i < 4; i++) begin
      Din1_Valid = vv[i]; Din1 = dd[i];
      tick();
      words += int'(Dout_Valid);
      aborts += int'(Abort);
      n_checks++;
      if ({Dout_Valid, Dout} !== {edv[i], edo[i]}) begin
        n_fails++;
        $display("FAIL backpressure_step%0d: DV=%b Dout=%h required DV=%b Dout=%h",
                 i, Dout_Valid, Dout, edv[i], edo[i]);
      end
    end
    Din1_Valid = 1'b0;
    n_checks++;
    if ({Gnt, Din1_Ready} !== 3'b000) begin
      n_fails++;
      $display("FAIL backpressure_release: Gnt=%b Ready=%b required 00 0", Gnt, Din1_Ready);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      words += int'(Dout_Valid);
      aborts += int'(Abort);
    end
    n_checks++;
    if (words !== 2 || aborts !== 0) begin
      n_fails++;
      $display("FAIL backpressure_totals: words=%0d aborts=%0d required 2 and 0", words, aborts);
    end
  endtask

  task automatic test_stall_abort;
    int abort_cnt = 0, abort_at = -1, dv_cnt = 0;
    Req0 = 1'b1; Len0 = 4'd5; Din0_Valid = 1'b0;
    tick();
    Req0 = 1'b0;
    wait_ready(0, "stall");
    Din0_Valid = 1'b1; Din0 = 4'h7;
    tick();
    Din0_Valid = 1'b0;
    n_checks++;
    if ({Dout_Valid, Dout} !== {1'b1, 4'h7}) begin
      n_fails++;
      $display("FAIL stall_first_word: DV=%b Dout=%h required DV=1 Dout=7", Dout_Valid, Dout);
    end
    for (int j = 1; j <= 12; j++) begin
      tick();
      dv_cnt += int'(Dout_Valid);
      if (Abort) begin
        abort_cnt++;
        abort_at = j;
        n_checks++;
        if (Gnt !== 2'b00) begin
          n_fails++;
          $display("FAIL stall_abort_gnt: Gnt=%b required 00", Gnt);
        end
      end
    end
    n_checks++;
    if (abort_cnt !== 1 || abort_at !== 8 || dv_cnt !== 0) begin
      n_fails++;
      $display("FAIL stall_abort: pulses=%0d at=%0d extra_words=%0d required 1 at 8 with 0",
               abort_cnt, abort_at, dv_cnt);
    end
    wait_idle("stall");
    Req0 = 1'b1; Req1 = 1'b1; Len0 = 4'd1; Len1 = 4'd1;
    tick();
    Req0 = 1'b0; Req1 = 1'b0;
    n_checks++;
    if (Gnt !== 2'b10) begin
      n_fails++;
      $display("FAIL stall_next_pref: Gnt=%b required 10", Gnt);
    end
    Din1_Valid = 1'b1;
    wait_idle("stall_next");
    Din1_Valid = 1'b0;
  endtask

  task automatic test_len_zero_reset;
    logic [11:0] obs;
    int words = 0;
    Req0 = 1'b1; Len0 = 4'd0; Din0 = 4'h3; Din0_Valid = 1'b1;
    tick();
    Req0 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (Dout_Valid) begin
        words++;
        n_checks++;
        if (Dout !== 4'h3) begin
          n_fails++;
          $display("FAIL len0_data: Dout=%h required 3", Dout);
        end
      end
    end
    Din0_Valid = 1'b0;
    n_checks++;
    if (words !== 1 || Busy !== 1'b0) begin
      n_fails++;
      $display("FAIL len0_words: words=%0d Busy=%b required 1 and 0", words, Busy);
    end
    Req1 = 1'b1; Len1 = 4'd4; Din1 = 4'h9; Din1_Valid = 1'b1;
    tick();
    Req1 = 1'b0;
    wait_ready(1, "midreset");
    tick(); tick();
    n_checks++;
    if ({Busy, Din1_Ready, Dout_Valid} !== 3'b111) begin
      n_fails++;
      $display("FAIL midreset_inxfer: Busy,Rdy,DV=%b required 111", {Busy, Din1_Ready, Dout_Valid});
    end
    #2 RSTn = 1'b0;
    #1;
    obs = {Gnt, Dout, Dout_Valid, ExtClk_En, Abort, Busy, Din0_Ready, Din1_Ready};
    n_checks++;
    if (obs !== 12'h000) begin
      n_fails++;
      $display("FAIL midreset_immediate: outputs=%h required 000", obs);
    end
    Din1_Valid = 1'b0;
    tick();
    RSTn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      obs = {Gnt, Dout, Dout_Valid, ExtClk_En, Abort, Busy, Din0_Ready, Din1_Ready};
      n_checks++;
      if (obs !== 12'h000) begin
        n_fails++;
        $display("FAIL postreset_cycle%0d: outputs=%h required 000", i, obs);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_contention();
    test_backpressure();
    test_stall_abort();
    test_len_zero_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
